// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and helpers for the RISC-V M-extension multiply/divide unit.
// It holds the funct3 operation encoding, the controller state encoding and
// the small decode helpers used for operand sign conditioning.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    // RISC-V M funct3 encoding
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

    // True for every divide-class operation (quotient or remainder)
    function automatic logic op_is_div(input muldiv_op_t op);
        logic res;
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: res = 1'b1;
            default:                          res = 1'b0;
        endcase
        return res;
    endfunction

    // True when the remainder is the returned value
    function automatic logic op_is_rem(input muldiv_op_t op);
        logic res;
        case (op)
            OP_REM, OP_REMU: res = 1'b1;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the signed divide-class operations (overflow can occur)
    function automatic logic op_is_sdiv(input muldiv_op_t op);
        logic res;
        case (op)
            OP_DIV, OP_REM: res = 1'b1;
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

    // src_a is interpreted as signed
    function automatic logic op_a_signed(input muldiv_op_t op);
        logic res;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: res = 1'b1;
            default:                                    res = 1'b0;
        endcase
        return res;
    endfunction

    // src_b is interpreted as signed
    function automatic logic op_b_signed(input muldiv_op_t op);
        logic res;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: res = 1'b1;
            default:                         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RISC-V M-extension multiply/divide unit sitting in EX beside the
// ALU. Multiplies use radix-2 shift-add, divides use restoring division, both
// on operand magnitudes with one bit per cycle and a single shared
// add/subtract datapath. Sign correction is applied to the final result.
// Divide-by-zero and signed overflow bypass iteration and complete in one
// cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      operation request, honoured only in IDLE
//   op         RISC-V M funct3
//   src_a      rs1 (multiplicand / dividend)
//   src_b      rs2 (multiplier / divisor)
//   flush      abort the operation in flight
//   stall_req  hold IF/ID/EX while an operation is being accepted or runs
//   done       one-cycle pulse, result valid
//   result     product half, quotient or remainder; held until next done
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int ADD_W = DATA_W + 2;

    localparam logic [DATA_W-1:0] ZERO_D   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONES_D   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ONE_D    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] MIN_D    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]  ZERO_ACC = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0]  ONE_ACC  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ITER_CNT = CNT_W'(DATA_W);

    // Registered state
    muldiv_state_t     state_r;
    muldiv_op_t        op_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ACC_W-1:0]  acc_r;
    logic [DATA_W-1:0] opnd_r;
    logic              neg_res_r;
    logic              neg_rem_r;
    logic [DATA_W-1:0] result_r;

    // Combinational signals
    muldiv_state_t     state_nxt_s;
    muldiv_op_t        op_in_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [DATA_W-1:0] mag_a_s;
    logic [DATA_W-1:0] mag_b_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              special_s;
    logic [DATA_W-1:0] special_res_s;
    logic [ACC_W-1:0]  init_acc_s;
    logic [DATA_W-1:0] init_opnd_s;
    logic [DATA_W:0]   rem_shift_s;
    logic [ADD_W-1:0]  add_a_s;
    logic [ADD_W-1:0]  add_b_s;
    logic              add_cin_s;
    logic [ADD_W-1:0]  sum_s;
    logic [ACC_W-1:0]  acc_step_s;
    logic [ACC_W-1:0]  prod_s;
    logic [DATA_W-1:0] quo_s;
    logic [DATA_W-1:0] rem_s;
    logic [DATA_W-1:0] final_s;
    logic              load_s;
    logic              iter_s;
    logic              fin_s;
    logic              stall_s;

    // Operand decode: sign conditioning, magnitudes and the one-cycle special cases
    always_comb begin
        op_in_s = muldiv_op_t'(op);
        a_neg_s = op_a_signed(op_in_s) & src_a[DATA_W-1];
        b_neg_s = op_b_signed(op_in_s) & src_b[DATA_W-1];

        if (a_neg_s) begin
            mag_a_s = ~src_a + ONE_D;
        end else begin
            mag_a_s = src_a;
        end

        if (b_neg_s) begin
            mag_b_s = ~src_b + ONE_D;
        end else begin
            mag_b_s = src_b;
        end

        div_zero_s = op_is_div(op_in_s) && (src_b == ZERO_D);
        div_ovf_s  = op_is_sdiv(op_in_s) && (src_a == MIN_D) && (src_b == ONES_D);
        special_s  = div_zero_s | div_ovf_s;

        if (div_zero_s) begin
            special_res_s = op_is_rem(op_in_s) ? src_a : ONES_D;
        end else if (div_ovf_s) begin
            special_res_s = op_is_rem(op_in_s) ? ZERO_D : src_a;
        end else begin
            special_res_s = ZERO_D;
        end

        // Multiply shifts the multiplier out of the low half; divide shifts
        // the dividend out of the low half into the partial remainder.
        if (op_is_div(op_in_s)) begin
            init_acc_s  = {ZERO_D, mag_a_s};
            init_opnd_s = mag_b_s;
        end else begin
            init_acc_s  = {ZERO_D, mag_b_s};
            init_opnd_s = mag_a_s;
        end
    end

    // Shared adder: adds the multiplicand in MUL, subtracts the divisor in DIV
    always_comb begin
        rem_shift_s = {acc_r[ACC_W-1:DATA_W], acc_r[DATA_W-1]};
        if (state_r == ST_DIV) begin
            add_a_s   = {1'b0, rem_shift_s};
            add_b_s   = ~{2'b00, opnd_r};
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = {2'b00, acc_r[ACC_W-1:DATA_W]};
            add_b_s   = {2'b00, opnd_r};
            add_cin_s = 1'b0;
        end
        sum_s = add_a_s + add_b_s + {{(ADD_W-1){1'b0}}, add_cin_s};
    end

    // One iteration step; a set sign bit of the difference means the trial
    // subtraction borrowed, so the shifted remainder is restored.
    always_comb begin
        if (state_r == ST_DIV) begin
            if (sum_s[ADD_W-1] == 1'b0) begin
                acc_step_s = {sum_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                acc_step_s = {sum_s[DATA_W:0], acc_r[DATA_W-1:1]};
            end else begin
                acc_step_s = {1'b0, acc_r[ACC_W-1:1]};
            end
        end
    end

    // Final result selection with sign correction, taken from the last step
    always_comb begin
        if (neg_res_r) begin
            prod_s = ~acc_step_s + ONE_ACC;
        end else begin
            prod_s = acc_step_s;
        end
        quo_s = acc_step_s[DATA_W-1:0];
        rem_s = acc_step_s[ACC_W-1:DATA_W];

        case (op_r)
            OP_MUL:                       final_s = prod_s[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_s[ACC_W-1:DATA_W];
            OP_DIV, OP_DIVU:              final_s = neg_res_r ? (~quo_s + ONE_D) : quo_s;
            OP_REM, OP_REMU:              final_s = neg_rem_r ? (~rem_s + ONE_D) : rem_s;
            default:                      final_s = ZERO_D;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and control decode
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        iter_s      = 1'b0;
        fin_s       = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    load_s  = 1'b1;
                    stall_s = 1'b1;
                    if (special_s) begin
                        state_nxt_s = ST_DONE;
                    end else if (op_is_div(op_in_s)) begin
                        state_nxt_s = ST_DIV;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                stall_s = 1'b1;
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    iter_s = 1'b1;
                    if (cnt_r == ONE_CNT) begin
                        fin_s       = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
            end
            ST_DONE: begin
                // The done pulse is already on the output; a flush here
                // changes nothing since the next state is IDLE anyway.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: operand capture, iteration and result latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r      <= OP_MUL;
            cnt_r     <= ZERO_CNT;
            acc_r     <= ZERO_ACC;
            opnd_r    <= ZERO_D;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= ZERO_D;
        end else begin
            if (load_s) begin
                op_r      <= op_in_s;
                cnt_r     <= ITER_CNT;
                acc_r     <= init_acc_s;
                opnd_r    <= init_opnd_s;
                neg_res_r <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
                if (special_s) begin
                    result_r <= special_res_s;
                end else begin
                    result_r <= result_r;
                end
            end else if (iter_s) begin
                acc_r <= acc_step_s;
                cnt_r <= cnt_r - ONE_CNT;
                if (fin_s) begin
                    result_r <= final_s;
                end else begin
                    result_r <= result_r;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // The accept term depends on the live start/flush inputs, so it is
    // gated by reset to stay low while reset is held.
    assign stall_req = reset & stall_s;
    assign done      = (state_r == ST_DONE);
    assign result    = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit at DATA_W=32: a table of directed
// vectors with hand-computed results and latencies, followed by hand-written
// sequences for start-during-iteration, flush, flush+start, flush in DONE and
// asynchronous reset mid-operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W     = 32;
    localparam int BOUND = 60;
    localparam int NVEC  = 24;

    localparam logic [2:0] C_MUL    = 3'b000;
    localparam logic [2:0] C_MULH   = 3'b001;
    localparam logic [2:0] C_MULHSU = 3'b010;
    localparam logic [2:0] C_MULHU  = 3'b011;
    localparam logic [2:0] C_DIV    = 3'b100;
    localparam logic [2:0] C_DIVU   = 3'b101;
    localparam logic [2:0] C_REM    = 3'b110;
    localparam logic [2:0] C_REMU   = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         stall_req;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs [NVEC];

    muldiv_unit #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Called at a negedge: present a request, sample stall_req in that cycle,
    // let the accept edge pass and drop start.
    task automatic launch(input logic [2:0] t_op, input logic [W-1:0] t_a,
                          input logic [W-1:0] t_b, output logic t_stall0);
        op    = t_op;
        src_a = t_a;
        src_b = t_b;
        start = 1'b1;
        #1;
        t_stall0 = stall_req;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count negedges after the accept edge until done; optionally pulse start
    // (MUL 3x5) in cycle pulse_at to show it is ignored.
    task automatic wait_done(input int pulse_at, output int t_lat, output logic t_stall_ok,
                             output logic t_done_stall, output logic t_mid_ok);
        logic [W-1:0] pre;
        pre          = result;
        t_lat        = -1;
        t_stall_ok   = 1'b1;
        t_done_stall = 1'b1;
        t_mid_ok     = 1'b1;
        for (int n = 1; n <= BOUND; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t_lat        = n;
                t_done_stall = stall_req;
                break;
            end
            if (stall_req !== 1'b1) t_stall_ok = 1'b0;
            if (result !== pre) t_mid_ok = 1'b0;
            if (n == pulse_at) begin
                start = 1'b1;
                op    = C_MUL;
                src_a = 32'd3;
                src_b = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic         s0;
        logic         sok;
        logic         dst;
        logic         mok;
        int           lat;
        int           ndone;
        logic [W-1:0] last_exp;

        vecs[0]  = '{C_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{C_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{C_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{C_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{C_DIVU,   32'd100,       32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[5]  = '{C_REMU,   32'd100,       32'h0000_0000, 32'd100,       1};
        vecs[6]  = '{C_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[7]  = '{C_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[8]  = '{C_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[9]  = '{C_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[10] = '{C_MUL,    32'd3,         32'd5,         32'd15,        33};
        vecs[11] = '{C_DIVU,   32'd100,       32'd7,         32'd14,        33};
        vecs[12] = '{C_REMU,   32'd100,       32'd7,         32'd2,         33};
        vecs[13] = '{C_DIV,    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 33};
        vecs[14] = '{C_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[15] = '{C_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[16] = '{C_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1};
        vecs[17] = '{C_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[18] = '{C_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        vecs[19] = '{C_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33};
        vecs[20] = '{C_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[21] = '{C_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[22] = '{C_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[23] = '{C_DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33};

        // Reset state, with a request already pending on the inputs
        reset = 1'b0;
        start = 1'b1;
        flush = 1'b0;
        op    = C_MUL;
        src_a = 32'd7;
        src_b = 32'd3;
        #12;
        check_bit("reset_stall_req", stall_req, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check("reset_result", result, 32'h0000_0000);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors, each launched in the cycle right after the
        // previous DONE
        @(negedge clk);
        last_exp = 32'h0000_0000;
        for (int i = 0; i < NVEC; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, s0);
            wait_done(0, lat, sok, dst, mok);
            check($sformatf("v%0d_result", i), result, vecs[i].exp);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check_bit($sformatf("v%0d_stall_accept", i), s0, 1'b1);
            check_bit($sformatf("v%0d_stall_busy", i), sok, 1'b1);
            check_bit($sformatf("v%0d_stall_in_done", i), dst, 1'b0);
            check_bit($sformatf("v%0d_result_stable_mid", i), mok, 1'b1);
            @(negedge clk);
            check_bit($sformatf("v%0d_done_one_cycle", i), done, 1'b0);
            check($sformatf("v%0d_result_hold", i), result, vecs[i].exp);
            last_exp = vecs[i].exp;
        end

        // start pulsed during a DIV is ignored
        launch(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002, s0);
        wait_done(5, lat, sok, dst, mok);
        check("ign_result", result, 32'hFFFF_FFFD);
        check("ign_latency", lat, 33);
        check_bit("ign_result_stable_mid", mok, 1'b1);
        check_bit("ign_stall_busy", sok, 1'b1);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ign_no_extra_done", ndone, 0);
        check("ign_result_after", result, 32'hFFFF_FFFD);

        // flush in cycle 10 of DIVU, then MUL 3x5 in the very next cycle
        @(negedge clk);
        launch(C_DIVU, 32'd1000, 32'd7, s0);
        repeat (9) @(negedge clk);
        @(negedge clk);
        check_bit("flush_busy_stall", stall_req, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_no_done", done, 1'b0);
        check_bit("flush_idle_stall", stall_req, 1'b0);
        check("flush_result_kept", result, 32'hFFFF_FFFD);
        launch(C_MUL, 32'd3, 32'd5, s0);
        wait_done(0, lat, sok, dst, mok);
        check_bit("post_flush_stall_accept", s0, 1'b1);
        check("post_flush_result", result, 32'd15);
        check("post_flush_latency", lat, 33);

        // flush and start together: request dropped
        @(negedge clk);
        op    = C_MUL;
        src_a = 32'd9;
        src_b = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check_bit("flush_start_stall", stall_req, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_start_idle", stall_req, 1'b0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("flush_start_no_done", ndone, 0);
        check("flush_start_result", result, 32'd15);

        // flush during DONE: pulse already presented completes, then IDLE
        @(negedge clk);
        launch(C_DIVU, 32'd100, 32'h0000_0000, s0);
        @(negedge clk);
        check_bit("fdone_done", done, 1'b1);
        check("fdone_result", result, 32'hFFFF_FFFF);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_bit("fdone_done_low", done, 1'b0);
        check_bit("fdone_idle_stall", stall_req, 1'b0);
        check("fdone_result_hold", result, 32'hFFFF_FFFF);

        // asynchronous reset mid-MUL, then a clean operation
        @(negedge clk);
        launch(C_MUL, 32'h0000_1234, 32'h0000_0010, s0);
        repeat (10) @(negedge clk);
        check_bit("pre_reset_stall", stall_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("async_rst_done", done, 1'b0);
        check_bit("async_rst_stall", stall_req, 1'b0);
        check("async_rst_result", result, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        launch(C_MUL, 32'h0000_1234, 32'h0000_0010, s0);
        wait_done(0, lat, sok, dst, mok);
        check("post_rst_result", result, 32'h0001_2340);
        check("post_rst_latency", lat, 33);
        check_bit("post_rst_stall_busy", sok, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_W, default 32, sets operand/result width; SHALL be even and >= 8.
REQ-002 Parameter CNT_W, default $clog2(DATA_W)+1, sets the iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 src_a  input  DATA_W  rs1 operand (multiplicand/dividend).
REQ-008 src_b  input  DATA_W  rs2 operand (multiplier/divisor).
REQ-009 flush  input  1  abort any operation in flight (branch/jump flush).
REQ-010 stall_req  output  1  hold the IF/ID/EX pipeline registers.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  DATA_W  selected product half, quotient or remainder.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-014 IDLE with start=1 and flush=0: capture op, sign-conditioned operands and magnitudes; load counter with DATA_W; go to MUL (op[2]=0) or DIV (op[2]=1).
REQ-015 start outside IDLE SHALL be ignored, with no operand capture.
REQ-016 MUL SHALL run radix-2 shift-add over a 2*DATA_W accumulator, one bit per cycle, for DATA_W cycles, then go to DONE.
REQ-017 DIV SHALL run restoring division on magnitudes, one quotient bit per cycle, for DATA_W cycles, then go to DONE.
REQ-018 Latency: done SHALL assert exactly DATA_W+1 cycles after the start-accept edge (33 cycles at DATA_W=32).
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE; start is accepted again in the cycle after DONE.
REQ-020 Sign rules: MUL/MULH treat both operands as signed; MULHSU treats src_a signed and src_b unsigned; MULHU, DIVU and REMU are unsigned.
REQ-021 Sign correction SHALL be applied to the final result: two's-complement of the product or quotient if operand signs differ; the remainder takes the dividend's sign.
REQ-022 MUL SHALL return product[DATA_W-1:0]; MULH, MULHSU and MULHU SHALL return product[2*DATA_W-1:DATA_W].
REQ-023 Divide by zero SHALL skip iteration and go IDLE->DONE directly (done 1 cycle after accept): quotient all ones; remainder = src_a.
REQ-024 Signed overflow (DIV/REM, src_a = most negative, src_b = all ones) SHALL take the same 1-cycle path: quotient = src_a; remainder 0.
REQ-025 stall_req = (IDLE & start & !flush) | MUL | DIV; it SHALL be deasserted in DONE so the pipeline advances with the result.
REQ-026 flush in any state SHALL return the FSM to IDLE on the next edge with no done pulse; flush and start in the same cycle: flush wins, and the request is dropped.
REQ-027 flush in DONE SHALL still complete the done pulse already presented, then go to IDLE.
REQ-028 result SHALL hold its last value until the next DONE; it SHALL not change mid-iteration.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counter 0, accumulators 0, result 0, done 0 and stall_req 0, regardless of clk or any operation in flight.
REQ-030 After reset release, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-031 The op encoding enum (muldiv_op_t) and the state enum (muldiv_state_t) SHALL live in a shared package, muldiv_pkg, imported by this unit and the controller.
REQ-032 No sub-module is required: one FSM with a shared add/subtract datapath; all operand sign conditioning is inline.
REQ-033 The unit SHALL sit in EX, in parallel with the ALU; the EX/MEM register samples result when done=1.

Verification (DATA_W=32)
REQ-034 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after accept, stall_req high for cycles 0-32.
REQ-035 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-036 DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, both with done 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, 1-cycle latency.
REQ-037 DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; start pulsed during iteration is ignored and the result is unchanged.
REQ-038 flush at cycle 10 of DIVU -> no done, IDLE next edge; start the next cycle with MUL 3x5 -> 15 after 33 cycles.
REQ-039 reset asserted mid-MUL, asynchronously between edges -> done, stall_req and result read 0 immediately; after release, a new operation completes correctly.
